tinyalu: RTL and testbench
==========================

# tinyalu

Operand-level ALU stage sitting directly downstream of the bus-functional driver: it samples `operands`/`op` on `start`, performs add, and, xor or multiply on two 8-bit operands, and returns a 16-bit `result` with a one-cycle `done` pulse. Single-cycle ops complete in 1 cycle and multiply in 3. The driver holds `start` until it sees `done`. This block is the DUT that the class-based testbench drives and checks.

## Interface
- `MUL_LATENCY`, 3, cycles from accept to `done` for `mul_op`; fixed, exposed for the bench only.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `operands`  in  16  `operandAB_T`: A = [15:8], B = [7:0], unsigned.
- `op`  in  3  `opcode_t`: no_op=0, add_op=1, and_op=2, xor_op=3, mul_op=4, 5–7 illegal (7 = rst_op is bench-only).
- `start`  in  1  request; level-held by the driver until `done` is seen.
- `done`  out  1  one-cycle pulse; `result` is valid in the same cycle.
- `result`  out  16  operation result; holds its last value between ops.
- `illegal`  out  1  only with `TINYALU_ILLEGAL_OP_EN`; pulses together with `done`.

## Operation
- FSM states: IDLE, MUL1, MUL2, MUL3.
- Accept condition: state == IDLE, `start`==1 and `done`==0 at a rising edge. Otherwise `start` is ignored. This gives a one-cycle lockout, so a `start` still high during the `done` cycle is never re-accepted.
- On accept, `operands` and `op` are captured. Later changes on the inputs have no effect on the op in flight.
- add_op: result = {7'b0, A+B}, with the 9-bit sum zero-extended.
- and_op: result = {8'b0, A&B}.
- xor_op: result = {8'b0, A^B}.
- Completion of add/and/xor: `done`=1 in the cycle after the accept edge, and state stays IDLE.
- mul_op: IDLE→MUL1→MUL2→MUL3→IDLE. result = A*B, 16-bit unsigned, no truncation.
- Completion of mul_op: `done`=1 in the cycle after the MUL3 edge.
- no_op: accepted but does nothing. No `done` is produced and `result` is unchanged.
- Illegal op (5–7) without the macro: behaves exactly like no_op.
- `done` never stays high for 2 consecutive cycles.

## Timing
- Reset values: `done`=0, `result`=16'h0000, `illegal`=0, state=IDLE, pipeline registers cleared.
- Latency from accept edge N:
  - add/and/xor: `done` is high during cycle N+1, i.e. after edge N.
  - mul: `done` is high during cycle N+3.
- `result` updates on the same edge that raises `done` and holds its value afterwards.
- Reset asserted mid-multiply aborts the op. No `done` is produced, and all outputs return to reset values on that edge.
- Reset and `start` on the same edge: reset wins and the op is not accepted.
- `start` dropping while a multiply is in flight does not cancel it; `done` still fires.
- Back-to-back throughput: one op per 2 cycles for single-cycle ops, one per 4 cycles for mul.

## Configuration
- `TINYALU_ILLEGAL_OP_EN` defined:
  - Adds the `illegal` port.
  - Opcodes 5–7 with `start` are accepted and complete like single-cycle ops: `done`=1 and `illegal`=1 after 1 cycle, with `result`=16'h0000.
- Macro undefined:
  - No `illegal` port.
  - Opcodes 5–7 are treated as no_op, so the driver waiting on `done` will hang. That is a bench error by design.

## Structure
- `tinyalu_pkg` holds the shared types and constants: `opcode_t` enum, `operandAB_T` packed struct {A[7:0], B[7:0]}, and `MUL_LATENCY`. These are shared with the driver and the scoreboard.
- Sub-module `tinyalu_mult`: 3-stage pipelined 8×8 unsigned multiplier with a valid shift chain. The top-level FSM uses its valid-out to raise `done`.
- Single-cycle ops are combinational in the top level, feeding a registered `result`.

## Test plan
- Reset, then add A=8'hFF, B=8'hFF → `done` one cycle after accept, result=16'h01FE.
- mul A=8'hFF, B=8'hFF → `done` exactly 3 cycles after accept, result=16'hFE01. Changing `operands` mid-flight leaves the result unchanged.
- and A=8'hF0, B=8'h3C → 16'h0030. Then xor with the same operands → 16'h00CC. Check the `start`-held lockout: each op produces exactly one `done` pulse.
- no_op with `start` held for 5 cycles → `done` stays 0 and `result` keeps its previous value.
- Assert `reset` during MUL2 of A=8'h10, B=8'h10 → no `done`, result=0. A following add of 1+2 → 16'h0003.
- With `TINYALU_ILLEGAL_OP_EN`: op=5, A=8'h12, B=8'h34 → `done`=1, `illegal`=1, result=0 after 1 cycle. Without the macro → no `done` within 10 cycles.

Source files
------------

// File: rtl/tinyalu_pkg.sv
// Shared types and constants for tinyalu, also used by the driver and scoreboard.
package tinyalu_pkg;

  localparam int MUL_LATENCY = 3;

  // Opcodes 5 and 6 are unnamed illegal values; rst_op is reserved for the bench.
  typedef enum logic [2:0] {
    no_op  = 3'd0,
    add_op = 3'd1,
    and_op = 3'd2,
    xor_op = 3'd3,
    mul_op = 3'd4,
    rst_op = 3'd7
  } opcode_t;

  typedef struct packed {
    logic [7:0] A;
    logic [7:0] B;
  } operandAB_T;

  typedef enum logic [1:0] {
    IDLE,
    MUL1,
    MUL2,
    MUL3
  } state_t;

endpackage

// File: rtl/tinyalu_mult.sv
// Pipelined 8x8 unsigned multiplier: operand capture, partial products, final add.
// The final add is combinational here and registered by the consumer as stage three.
module tinyalu_mult (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        valid_out,
  output logic [15:0] product
);

  logic [7:0]  a_q;
  logic [7:0]  b_q;
  logic        v1_q;
  logic [11:0] pp_lo_q;
  logic [11:0] pp_hi_q;
  logic        v2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      v1_q    <= 1'b0;
      pp_lo_q <= 12'h000;
      pp_hi_q <= 12'h000;
      v2_q    <= 1'b0;
    end else begin
      v1_q <= valid_in;
      if (valid_in) begin
        a_q <= a;
        b_q <= b;
      end
      // Split B into nibbles so each stage only carries an 8x4 product.
      v2_q    <= v1_q;
      pp_lo_q <= {4'h0, a_q} * {8'h00, b_q[3:0]};
      pp_hi_q <= {4'h0, a_q} * {8'h00, b_q[7:4]};
    end
  end

  assign product   = {4'h0, pp_lo_q} + {pp_hi_q, 4'h0};
  assign valid_out = v2_q;

endmodule

// File: rtl/tinyalu.sv
// tinyalu top: accept/lockout FSM, single-cycle ops and multiplier sequencing.
// Optional feature macro: TINYALU_ILLEGAL_OP_EN (adds the illegal port and completes opcodes 5-7).
module tinyalu
  import tinyalu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  operandAB_T  operands,
  input  opcode_t     op,
  input  logic        start,
  output logic        done,
  output logic [15:0] result
`ifdef TINYALU_ILLEGAL_OP_EN
  ,
  output logic        illegal
`endif
);

  state_t      state;
  logic        accept;
  logic        mul_start;
  logic        mul_valid;
  logic [15:0] mul_product;
  logic        sc_done;
  logic [15:0] sc_result;
`ifdef TINYALU_ILLEGAL_OP_EN
  logic        sc_illegal;
`endif

  // The done term gives the one-cycle lockout for a start still held during done.
  assign accept    = (state == IDLE) && start && !done;
  assign mul_start = accept && (op == mul_op);

  tinyalu_mult u_mult (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (mul_start),
    .a         (operands.A),
    .b         (operands.B),
    .valid_out (mul_valid),
    .product   (mul_product)
  );

  always_comb begin
    sc_done   = 1'b0;
    sc_result = 16'h0000;
`ifdef TINYALU_ILLEGAL_OP_EN
    sc_illegal = 1'b0;
`endif
    if (accept) begin
      case (op)
        add_op: begin
          sc_done   = 1'b1;
          sc_result = {7'b0, {1'b0, operands.A} + {1'b0, operands.B}};
        end
        and_op: begin
          sc_done   = 1'b1;
          sc_result = {8'h00, operands.A & operands.B};
        end
        xor_op: begin
          sc_done   = 1'b1;
          sc_result = {8'h00, operands.A ^ operands.B};
        end
`ifdef TINYALU_ILLEGAL_OP_EN
        no_op, mul_op: begin
        end
        default: begin
          sc_done    = 1'b1;
          sc_illegal = 1'b1;
        end
`else
        default: begin
        end
`endif
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      done   <= 1'b0;
      result <= 16'h0000;
`ifdef TINYALU_ILLEGAL_OP_EN
      illegal <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef TINYALU_ILLEGAL_OP_EN
      illegal <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (mul_start) begin
            state <= MUL1;
          end else if (sc_done) begin
            done   <= 1'b1;
            result <= sc_result;
`ifdef TINYALU_ILLEGAL_OP_EN
            illegal <= sc_illegal;
`endif
          end
        end
        MUL1: state <= MUL2;
        MUL2: begin
          state <= MUL3;
          if (mul_valid) begin
            done   <= 1'b1;
            result <= mul_product;
          end
        end
        MUL3: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tinyalu.sv
// Directed self-checking bench for tinyalu; covers the illegal-op path when TINYALU_ILLEGAL_OP_EN is defined.
module tb_tinyalu;
  import tinyalu_pkg::*;

  logic        clk;
  logic        reset;
  operandAB_T  operands;
  opcode_t     op;
  logic        start;
  logic        done;
  logic [15:0] result;
`ifdef TINYALU_ILLEGAL_OP_EN
  logic        illegal;
`endif

  int compared   = 0;
  int mismatched = 0;

  tinyalu dut (
    .clk      (clk),
    .reset    (reset),
    .operands (operands),
    .op       (op),
    .start    (start),
    .done     (done),
    .result   (result)
`ifdef TINYALU_ILLEGAL_OP_EN
    ,
    .illegal  (illegal)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input opcode_t o, input logic [7:0] a, input logic [7:0] b);
    op       = o;
    operands = '{A: a, B: b};
    start    = 1'b1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Counts cycles after the accept edge until done is seen, capped at 10.
  task automatic waitDone(output int cycles);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (done !== 1'b1 && cycles < 10);
    if (done !== 1'b1) cycles = 99;
  endtask

  int lat;
  int pulses;

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    op       = no_op;
    operands = '{A: 8'h00, B: 8'h00};
    tick();
    tick();
    checkOutput("reset_done", {15'b0, done}, 16'h0000);
    checkOutput("reset_result", result, 16'h0000);
`ifdef TINYALU_ILLEGAL_OP_EN
    checkOutput("reset_illegal", {15'b0, illegal}, 16'h0000);
`endif
    reset = 1'b0;
    tick();

    // add FF+FF, start held through the done cycle
    applyStimulus(add_op, 8'hFF, 8'hFF);
    waitDone(lat);
    checkOutput("add_latency", 16'(lat), 16'd1);
    checkOutput("add_result", result, 16'h01FE);
    start = 1'b0;
    tick();
    checkOutput("add_done_pulse", {15'b0, done}, 16'h0000);
    checkOutput("add_result_hold", result, 16'h01FE);

    // mul FF*FF with operands and op changed mid-flight
    applyStimulus(mul_op, 8'hFF, 8'hFF);
    tick();
    checkOutput("mul_c1_done", {15'b0, done}, 16'h0000);
    applyStimulus(add_op, 8'h01, 8'h01);
    tick();
    checkOutput("mul_c2_done", {15'b0, done}, 16'h0000);
    tick();
    checkOutput("mul_c3_done", {15'b0, done}, 16'h0001);
    checkOutput("mul_result", result, 16'hFE01);
    start = 1'b0;
    tick();
    checkOutput("mul_done_pulse", {15'b0, done}, 16'h0000);
    checkOutput("mul_result_hold", result, 16'hFE01);

    // and, then lockout check with start held one extra edge
    applyStimulus(and_op, 8'hF0, 8'h3C);
    pulses = 0;
    waitDone(lat);
    checkOutput("and_latency", 16'(lat), 16'd1);
    checkOutput("and_result", result, 16'h0030);
    tick();
    checkOutput("and_lockout", {15'b0, done}, 16'h0000);
    start = 1'b0;
    tick();

    applyStimulus(xor_op, 8'hF0, 8'h3C);
    waitDone(lat);
    checkOutput("xor_latency", 16'(lat), 16'd1);
    checkOutput("xor_result", result, 16'h00CC);
    tick();
    checkOutput("xor_lockout", {15'b0, done}, 16'h0000);
    start = 1'b0;
    tick();

    // no_op held for 5 cycles
    applyStimulus(no_op, 8'h55, 8'hAA);
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done) pulses++;
    end
    checkOutput("noop_done_count", 16'(pulses), 16'd0);
    checkOutput("noop_result_hold", result, 16'h00CC);
    start = 1'b0;
    tick();

    // start dropped after accept does not cancel a multiply
    applyStimulus(mul_op, 8'h03, 8'h05);
    tick();
    start = 1'b0;
    tick();
    tick();
    checkOutput("mul_nocancel_done", {15'b0, done}, 16'h0001);
    checkOutput("mul_nocancel_result", result, 16'h000F);
    tick();
    tick();

    // reset during MUL2 aborts the multiply
    applyStimulus(mul_op, 8'h10, 8'h10);
    tick();
    start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    checkOutput("abort_done", {15'b0, done}, 16'h0000);
    checkOutput("abort_result", result, 16'h0000);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done) pulses++;
    end
    checkOutput("abort_no_late_done", 16'(pulses), 16'd0);

    applyStimulus(add_op, 8'h01, 8'h02);
    waitDone(lat);
    checkOutput("add12_latency", 16'(lat), 16'd1);
    checkOutput("add12_result", result, 16'h0003);
    start = 1'b0;
    tick();

    // opcode 5
    applyStimulus(opcode_t'(3'd5), 8'h12, 8'h34);
`ifdef TINYALU_ILLEGAL_OP_EN
    waitDone(lat);
    checkOutput("illegal_latency", 16'(lat), 16'd1);
    checkOutput("illegal_flag", {15'b0, illegal}, 16'h0001);
    checkOutput("illegal_result", result, 16'h0000);
    start = 1'b0;
    tick();
    checkOutput("illegal_flag_pulse", {15'b0, illegal}, 16'h0000);
`else
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done) pulses++;
    end
    checkOutput("illegal_no_done", 16'(pulses), 16'd0);
    checkOutput("illegal_result_hold", result, 16'h0003);
    start = 1'b0;
    tick();
`endif

    // reset and start on the same edge: reset wins
    applyStimulus(add_op, 8'h01, 8'h01);
    reset = 1'b1;
    tick();
    checkOutput("rst_start_done", {15'b0, done}, 16'h0000);
    checkOutput("rst_start_result", result, 16'h0000);
    reset = 1'b0;
    start = 1'b0;
    tick();
    checkOutput("rst_start_no_late", {15'b0, done}, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
